// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: enable/mask control, ADC start/done handshake and result readback of the scan sequencer
interface adc_scan_sequencer_if #(
   parameter int N_CH = 4
);
   logic            enable_i;
   logic [N_CH-1:0] ch_mask_i;
   logic            init_signal_o;
   logic [2:0]      address_out_o;
   logic            done_pulse_i;
   logic [7:0]      data_in_i;
   logic [2:0]      rd_ch_i;
   logic [7:0]      rd_data_o;
   logic [N_CH-1:0] valid_mask_o;
   logic            busy_o;
   logic            scan_done_o;
   logic            overrun_o;
   logic            timeout_err_o;
   modport slave (
      input  enable_i, ch_mask_i, done_pulse_i, data_in_i, rd_ch_i,
      output init_signal_o, address_out_o, rd_data_o, valid_mask_o, busy_o, scan_done_o, overrun_o, timeout_err_o
   );
   modport master (
      output enable_i, ch_mask_i, done_pulse_i, data_in_i, rd_ch_i,
      input  init_signal_o, address_out_o, rd_data_o, valid_mask_o, busy_o, scan_done_o, overrun_o, timeout_err_o
   );
endinterface

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: periodic masked ADC channel scan; define ADC_SCAN_TIMEOUT_EN to add the WAIT_DONE watchdog
module adc_scan_sequencer #(
   parameter int N_CH       = 4,
   parameter int SAMPLE_DIV = 1000,
   parameter int TIMEOUT    = 4095
) (
   input logic                 clk,
   input logic                 reset,
   adc_scan_sequencer_if.slave bus
);
   localparam int CW = $clog2(SAMPLE_DIV);
   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT_DONE, NEXT} state_t;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      ch_q, ch_d, low_ch, nxt_ch;
   logic [N_CH-1:0] mask_q, mask_d, valid_q, valid_d;
   logic [7:0]      res_q [8];
   logic            tick, has_nxt, wr, ovr_q, to_hit;
   assign tick  = bus.enable_i && cnt_q == CW'(SAMPLE_DIV - 1);
   assign cnt_d = (!bus.enable_i || tick) ? '0 : cnt_q + 1'b1;
   assign bus.init_signal_o = state_q == START;
   assign bus.address_out_o = ch_q;
   assign bus.busy_o        = state_q != IDLE;
   assign bus.scan_done_o   = state_q == NEXT && !has_nxt;
   assign bus.overrun_o     = ovr_q;
   assign bus.valid_mask_o  = valid_q;
   assign bus.rd_data_o     = 32'(bus.rd_ch_i) < N_CH ? res_q[bus.rd_ch_i] : 8'h00;
`ifdef ADC_SCAN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_q;
   logic          to_err_q;
   assign to_hit = state_q == WAIT_DONE && !bus.done_pulse_i && to_q == TW'(TIMEOUT - 1);
   assign bus.timeout_err_o = to_err_q;
   // watchdog: count cycles spent in WAIT_DONE, sticky error when it expires
   always_ff @(posedge clk) begin
      if (reset) begin
         to_q     <= '0;
         to_err_q <= 1'b0;
      end else begin
         to_q     <= state_q == WAIT_DONE ? to_q + 1'b1 : '0;
         to_err_q <= to_err_q | to_hit;
      end
   end
`else
   // no watchdog: WAIT_DONE waits forever; TIMEOUT (always >= 1) only feeds a constant-zero error flag
   assign to_hit = 1'b0;
   assign bus.timeout_err_o = TIMEOUT < 0;
`endif
   // lowest requested channel for a new scan and next latched channel above the current one
   always_comb begin
      low_ch  = '0;
      nxt_ch  = '0;
      has_nxt = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (bus.ch_mask_i[i]) low_ch = 3'(i);
         if (mask_q[i] && 3'(i) > ch_q) begin
            nxt_ch  = 3'(i);
            has_nxt = 1'b1;
         end
      end
   end
   // scan FSM next state, channel walk and result write strobe
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      mask_d  = mask_q;
      valid_d = valid_q;
      wr      = 1'b0;
      case (state_q)
         IDLE: if (tick && |bus.ch_mask_i) begin
            state_d = SETUP;
            mask_d  = bus.ch_mask_i;
            ch_d    = low_ch;
         end
         SETUP: state_d = START;
         START: state_d = WAIT_DONE;
         WAIT_DONE: if (bus.done_pulse_i) begin
            wr      = 1'b1;
            state_d = NEXT;
            for (int i = 0; i < N_CH; i++) if (ch_q == 3'(i)) valid_d[i] = 1'b1;
         end else if (to_hit) state_d = NEXT;
         NEXT: begin
            state_d = has_nxt ? SETUP : IDLE;
            ch_d    = has_nxt ? nxt_ch : ch_q;
         end
         default: state_d = IDLE;
      endcase
   end
   // control state registers; a tick arriving while busy is dropped and flagged
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ch_q    <= '0;
         mask_q  <= '0;
         valid_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_q | (tick && state_q != IDLE);
      end
   end
   // conversion result storage
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) res_q[i] <= 8'h00;
      end else if (wr) begin
         res_q[ch_q] <= bus.data_in_i;
      end
   end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed and randomized scans against a scoreboard fed by a behavioural ADC model
module tb_adc_scan_sequencer;
   localparam int NC = 4;
   localparam int DIV = 16;
   localparam int TO = 32;
   logic clk = 1'b0;
   logic reset;
   int vectors = 0, errs = 0;
   adc_scan_sequencer_if #(.N_CH(NC)) bus ();
   adc_scan_sequencer #(.N_CH(NC), .SAMPLE_DIV(DIV), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
   initial forever #5 clk = ~clk;
   logic [7:0] exp_res [8];
   logic [7:0] exp_valid = '0;
   logic [2:0] addr_log [$];
   int         init_cyc [$];
   logic [7:0] data_q [$];
   int cyc = 0, sd_cnt = 0, sd_last = 0;
   int dly = 5, no_ans = -1, epoch = 0;
   bit accept = 1'b1;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.init_signal_o) begin
         addr_log.push_back(bus.address_out_o);
         init_cyc.push_back(cyc);
      end
      if (bus.scan_done_o) begin
         sd_cnt++;
         sd_last = cyc;
      end
   end
   // ADC model: answers each start request dly cycles later, unless the channel is set to never answer
   initial begin
      int pend = 0, seen = 0;
      logic [2:0] pch = '0;
      logic [7:0] pdata = '0;
      forever begin
         @(negedge clk);
         bus.done_pulse_i = 1'b0;
         if (epoch != seen) begin
            seen = epoch;
            pend = 0;
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.done_pulse_i = 1'b1;
               bus.data_in_i = pdata;
               if (accept) begin
                  exp_res[pch] = pdata;
                  exp_valid[pch] = 1'b1;
               end
            end
         end
         if (bus.init_signal_o && int'(bus.address_out_o) != no_ans) begin
            pch = bus.address_out_o;
            pdata = data_q.size() > 0 ? data_q.pop_front() : 8'($urandom);
            pend = dly;
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, bus.busy_o, 0);
      chk({tag, "_init"}, bus.init_signal_o, 0);
      chk({tag, "_addr"}, bus.address_out_o, 0);
      chk({tag, "_sdone"}, bus.scan_done_o, 0);
      chk({tag, "_ovr"}, bus.overrun_o, 0);
      chk({tag, "_to"}, bus.timeout_err_o, 0);
      chk({tag, "_valid"}, bus.valid_mask_o, 0);
   endtask
   task automatic chk_results(input string tag);
      for (int c = 0; c < 8; c++) begin
         bus.rd_ch_i = 3'(c);
         #1;
         chk({tag, "_rd"}, bus.rd_data_o, c < NC ? exp_res[c] : 8'h00);
      end
      chk({tag, "_vmask"}, bus.valid_mask_o, exp_valid[NC-1:0]);
   endtask
   task automatic wait_init(input int n, input int budget, input string tag);
      int k = 0;
      while (addr_log.size() <= n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      chk(tag, addr_log.size() > n, 1);
   endtask
   task automatic wait_sd(input int n, input int budget, input string tag);
      int k = 0;
      while (sd_cnt <= n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      chk(tag, sd_cnt, n + 1);
   endtask
   task automatic do_reset();
      bus.enable_i = 1'b0;
      reset = 1'b1;
      epoch++;
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b0;
      exp_res = '{default: '0};
      exp_valid = '0;
   endtask
   initial begin
      int a0, s0, j, nt;
      logic [3:0] m;
      logic saw;
      reset = 1'b1;
      bus.enable_i = 1'b0;
      bus.ch_mask_i = '0;
      bus.rd_ch_i = '0;
      exp_res = '{default: '0};
      repeat (3) @(negedge clk);
      #1;
      chk_idle("rst");
      chk_results("rst");
      reset = 1'b0;
      // two-channel scan with fixed data, latency of the first result
      a0 = addr_log.size(); s0 = sd_cnt;
      data_q = '{8'h3C, 8'hA5};
      dly = 5;
      bus.ch_mask_i = 4'b1010;
      bus.rd_ch_i = 3'd1;
      bus.enable_i = 1'b1;
      wait_init(a0, 40, "a_init");
      chk("a_addr0", bus.address_out_o, 1);
      @(negedge clk); #1;
      chk("a_init_1cyc", bus.init_signal_o, 0);
      chk("a_addr_hold", bus.address_out_o, 1);
      repeat (4) @(negedge clk);
      #1;
      chk("a_rd_pre", bus.rd_data_o, 0);
      @(negedge clk); #1;
      chk("a_rd_lat", bus.rd_data_o, 8'h3C);
      wait_sd(s0, 60, "a_sd");
      bus.enable_i = 1'b0;
      chk("a_addr1", addr_log[a0 + 1], 3);
      chk("a_res3", exp_res[3], 8'hA5);
      chk_results("a");
      repeat (20) @(negedge clk);
      #1;
      chk("a_one_sd", sd_cnt, s0 + 1);
      chk("a_nscan", addr_log.size(), a0 + 2);
      // random masks and ADC latencies; mask changes mid-scan must be ignored
      for (int k = 0; k < 5; k++) begin
         a0 = addr_log.size(); s0 = sd_cnt;
         m = 4'($urandom_range(1, 15));
         dly = $urandom_range(1, 6);
         bus.ch_mask_i = m;
         bus.enable_i = 1'b1;
         wait_init(a0, 40, "rnd_init");
         bus.ch_mask_i = 4'($urandom);
         wait_sd(s0, 120, "rnd_sd");
         bus.enable_i = 1'b0;
         j = 0;
         for (int i = 0; i < NC; i++) if (m[i]) begin
            chk("rnd_addr", addr_log[a0 + j], i);
            j++;
         end
         chk("rnd_cnt", addr_log.size(), a0 + j);
         chk_results("rnd");
      end
      // empty mask: ticks ignored
      do_reset();
      a0 = addr_log.size();
      bus.ch_mask_i = 4'b0000;
      bus.enable_i = 1'b1;
      saw = 1'b0;
      repeat (64) begin
         @(negedge clk); #1;
         saw = saw | bus.init_signal_o | bus.busy_o;
      end
      chk("zero_activity", saw, 0);
      chk("zero_nscan", addr_log.size(), a0);
      // slow ADC: tick during WAIT_DONE is dropped, next scan on the first tick after idle
      do_reset();
      a0 = addr_log.size(); s0 = sd_cnt;
      dly = 20;
      bus.ch_mask_i = 4'b0001;
      bus.enable_i = 1'b1;
      wait_init(a0, 40, "ovr_init");
      wait_sd(s0, 60, "ovr_sd");
      chk("ovr_flag", bus.overrun_o, 1);
      nt = init_cyc[a0] - 2 + DIV;
      while (nt <= sd_last) nt += DIV;
      wait_init(a0 + 1, 60, "ovr_init2");
      chk("ovr_restart", init_cyc[a0 + 1], nt + 2);
      bus.enable_i = 1'b0;
      // one-cycle reset during WAIT_DONE; the late done pulse is ignored
      do_reset();
      a0 = addr_log.size();
      dly = 10;
      bus.ch_mask_i = 4'b0001;
      bus.rd_ch_i = 3'd0;
      bus.enable_i = 1'b1;
      wait_init(a0, 40, "mrst_init");
      repeat (3) @(negedge clk);
      #1;
      bus.enable_i = 1'b0;
      accept = 1'b0;
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      chk_idle("mrst");
      chk("mrst_rd", bus.rd_data_o, 0);
      repeat (15) @(negedge clk);
      #1;
      chk("mrst_late_valid", bus.valid_mask_o, 0);
      chk("mrst_late_rd", bus.rd_data_o, 0);
      chk("mrst_late_busy", bus.busy_o, 0);
      accept = 1'b1;
      // enable dropped during channel 0 of a full scan
      do_reset();
      a0 = addr_log.size(); s0 = sd_cnt;
      dly = 3;
      bus.ch_mask_i = 4'b1111;
      bus.enable_i = 1'b1;
      wait_init(a0, 40, "edrop_init");
      bus.enable_i = 1'b0;
      wait_sd(s0, 80, "edrop_sd");
      for (int i = 0; i < NC; i++) chk("edrop_addr", addr_log[a0 + i], i);
      chk_results("edrop");
      repeat (40) @(negedge clk);
      #1;
      chk("edrop_no_more_sd", sd_cnt, s0 + 1);
      chk("edrop_no_more_init", addr_log.size(), a0 + 4);
      chk("edrop_busy", bus.busy_o, 0);
`ifdef ADC_SCAN_TIMEOUT_EN
      // channel 0 never answered: watchdog expires, channel 1 still converts
      do_reset();
      a0 = addr_log.size(); s0 = sd_cnt;
      dly = 4;
      no_ans = 0;
      bus.ch_mask_i = 4'b0011;
      bus.enable_i = 1'b1;
      wait_init(a0, 40, "to_init");
      bus.enable_i = 1'b0;
      repeat (TO) @(negedge clk);
      #1;
      chk("to_not_yet", bus.timeout_err_o, 0);
      @(negedge clk); #1;
      chk("to_flag", bus.timeout_err_o, 1);
      wait_sd(s0, 60, "to_sd");
      chk("to_addr1", addr_log[a0 + 1], 1);
      chk_results("to");
      no_ans = -1;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
